// File: rtl/stream_fifo_if.sv
// stream_channel: AXI-Stream style channel with full per-beat sideband.
// The master modport drives everything except t_ready; the slave modport drives only t_ready.
interface stream_channel #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DEST_W = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned USER_W = 4
) (
  input logic clk,
  input logic rstn
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              t_valid;
  logic              t_ready;
  logic [ID_W-1:0]   t_id;
  logic [DEST_W-1:0] t_dest;
  logic [DATA_W-1:0] t_data;
  logic [STRB_W-1:0] t_strb;
  logic [STRB_W-1:0] t_keep;
  logic              t_last;
  logic [USER_W-1:0] t_user;

  modport master (
    input  clk, rstn, t_ready,
    output t_valid, t_id, t_dest, t_data, t_strb, t_keep, t_last, t_user
  );

  modport slave (
    input  clk, rstn, t_valid, t_id, t_dest, t_data, t_strb, t_keep, t_last, t_user,
    output t_ready
  );
endinterface

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous stream FIFO buffering up to DEPTH beats with all sideband.
// Define STREAM_FIFO_PACKET_MODE_EN for store-and-forward; the default build is cut-through.
module stream_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  stream_channel.slave               s,
  stream_channel.master              m,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned W     = $bits({s.t_id, s.t_dest, s.t_data, s.t_strb,
                                         s.t_keep, s.t_last, s.t_user});

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full_c;
  logic             m_valid_c;
  logic             push_c;
  logic             pop_c;

  assign full_c    = (level == LVL_W'(DEPTH));
  assign s.t_ready = ~full_c;
  assign push_c    = s.t_valid & ~full_c;
  assign pop_c     = m_valid_c & m.t_ready;
  assign m.t_valid = m_valid_c;

`ifdef STREAM_FIFO_PACKET_MODE_EN
  logic [LVL_W-1:0] pkt_cnt;
  logic             hold;

  // hold keeps a presented beat valid until it pops, even if the release term drops
  assign m_valid_c = (level != '0) & ((pkt_cnt != '0) | full_c | hold);

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
      hold    <= 1'b0;
    end else begin
      hold <= m_valid_c & ~m.t_ready;
      case ({push_c & s.t_last, pop_c & m.t_last})
        2'b10:   pkt_cnt <= pkt_cnt + LVL_W'(1);
        2'b01:   pkt_cnt <= pkt_cnt - LVL_W'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end
`else
  assign m_valid_c = (level != '0);
`endif

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; contents are meaningless while level is zero
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= {s.t_id, s.t_dest, s.t_data, s.t_strb, s.t_keep, s.t_last, s.t_user};
    end
  end

  assign {m.t_id, m.t_dest, m.t_data, m.t_strb, m.t_keep, m.t_last, m.t_user} = mem[rd_ptr];
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: scoreboard bench for stream_fifo at DEPTH=8 (honours STREAM_FIFO_PACKET_MODE_EN).
`timescale 1ns/1ps
module tb_stream_fifo;
  typedef struct packed {
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [15:0] data;
    logic [1:0]  strb;
    logic [1:0]  keep;
    logic        last;
    logic [3:0]  user;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rstn;
  logic [3:0] level;
  int         n_checks = 0;
  int         n_fail   = 0;
  beat_t      sb[$];

  assign rstn = ~rst;
  always #5 clk = ~clk;

  stream_channel #(.ID_W(4), .DEST_W(4), .DATA_W(16), .USER_W(4)) s_if (.clk(clk), .rstn(rstn));
  stream_channel #(.ID_W(4), .DEST_W(4), .DATA_W(16), .USER_W(4)) m_if (.clk(clk), .rstn(rstn));

  stream_fifo #(.DEPTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .s     (s_if),
    .m     (m_if),
    .level (level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic l);
    s_if.t_valid = v;
    s_if.t_data  = d;
    s_if.t_last  = l;
    s_if.t_id    = 4'($urandom);
    s_if.t_dest  = 4'($urandom);
    s_if.t_strb  = 2'($urandom);
    s_if.t_keep  = 2'($urandom);
    s_if.t_user  = 4'($urandom);
  endtask

  // Scoreboard: record accepted beats, compare every field of each popped beat
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (m_if.t_valid && m_if.t_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("t_id",   32'(m_if.t_id),   32'(e.id));
          check("t_dest", 32'(m_if.t_dest), 32'(e.dest));
          check("t_data", 32'(m_if.t_data), 32'(e.data));
          check("t_strb", 32'(m_if.t_strb), 32'(e.strb));
          check("t_keep", 32'(m_if.t_keep), 32'(e.keep));
          check("t_last", 32'(m_if.t_last), 32'(e.last));
          check("t_user", 32'(m_if.t_user), 32'(e.user));
        end
      end
      if (s_if.t_valid && s_if.t_ready) begin
        sb.push_back('{id: s_if.t_id, dest: s_if.t_dest, data: s_if.t_data,
                       strb: s_if.t_strb, keep: s_if.t_keep, last: s_if.t_last,
                       user: s_if.t_user});
      end
    end
  end

  initial begin
    drive(1'b0, 16'h0, 1'b0);
    m_if.t_ready = 1'b0;

    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_m_valid", 32'(m_if.t_valid), 32'd0);
    check("rst_s_ready", 32'(s_if.t_ready), 32'd1);
    check("rst_level",   32'(level),        32'd0);

    // Burst then drain
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'(i), i == 4);
      step();
      if (i == 1) begin
`ifdef STREAM_FIFO_PACKET_MODE_EN
        check("burst_first_valid", 32'(m_if.t_valid), 32'd0);
`else
        check("burst_first_valid", 32'(m_if.t_valid), 32'd1);
`endif
      end
    end
    drive(1'b0, 16'h0, 1'b0);
    check("burst_level", 32'(level), 32'd4);
    m_if.t_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(m_if.t_valid), 32'd1);
      step();
    end
    m_if.t_ready = 1'b0;
    check("drain_level", 32'(level),        32'd0);
    check("drain_empty", 32'(m_if.t_valid), 32'd0);

    // Fill to full, hold a ninth beat, then release one slot
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h10 + 16'(i), 1'b1);
      step();
    end
    check("fill_level",   32'(level),        32'd8);
    check("fill_s_ready", 32'(s_if.t_ready), 32'd0);
    drive(1'b1, 16'h99, 1'b1);
    step();
    check("held_level",   32'(level),        32'd8);
    m_if.t_ready = 1'b1;
    step();
    m_if.t_ready = 1'b0;
    check("pop1_level",   32'(level),        32'd7);
    check("pop1_s_ready", 32'(s_if.t_ready), 32'd1);
    step();
    drive(1'b0, 16'h0, 1'b0);
    check("ninth_level",  32'(level),        32'd8);
    m_if.t_ready = 1'b1;
    repeat (8) step();
    m_if.t_ready = 1'b0;
    check("fill_drained", 32'(level), 32'd0);

    // Steady state at level 3 across pointer wrap
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h30 + 16'(i), 1'b1);
      step();
    end
    m_if.t_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 16'h40 + 16'(i), 1'b1);
      step();
      check("steady_level", 32'(level), 32'd3);
    end
    drive(1'b0, 16'h0, 1'b0);
    repeat (3) step();
    m_if.t_ready = 1'b0;
    check("steady_drained", 32'(level), 32'd0);

    // Reset mid-stream at level 5
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h50 + 16'(i), 1'b1);
      step();
    end
    check("pre_rst_level", 32'(level), 32'd5);
    drive(1'b1, 16'h5F, 1'b1);
    m_if.t_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0);
    m_if.t_ready = 1'b0;
    check("mid_rst_level",   32'(level),        32'd0);
    check("mid_rst_m_valid", 32'(m_if.t_valid), 32'd0);
    check("mid_rst_s_ready", 32'(s_if.t_ready), 32'd1);
    drive(1'b1, 16'h60, 1'b1);
    step();
    drive(1'b1, 16'h61, 1'b1);
    step();
    drive(1'b0, 16'h0, 1'b0);
    m_if.t_ready = 1'b1;
    repeat (2) step();
    m_if.t_ready = 1'b0;
    check("post_rst_drained", 32'(level), 32'd0);

`ifdef STREAM_FIFO_PACKET_MODE_EN
    // Store-and-forward: nothing presented until a last beat is stored
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h70 + 16'(i), 1'b0);
      step();
      check("pkt_wait_valid", 32'(m_if.t_valid), 32'd0);
    end
    drive(1'b1, 16'h73, 1'b1);
    step();
    drive(1'b0, 16'h0, 1'b0);
    check("pkt_release_valid", 32'(m_if.t_valid), 32'd1);
    m_if.t_ready = 1'b1;
    repeat (4) step();
    m_if.t_ready = 1'b0;
    check("pkt_drained", 32'(level), 32'd0);

    // Oversized packet is released on reaching full
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h80 + 16'(i), 1'b0);
      step();
      check("big_valid", 32'(m_if.t_valid), (i == 7) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 16'h0, 1'b0);
    m_if.t_ready = 1'b1;
    step();
    check("big_after_pop_valid", 32'(m_if.t_valid), 32'd0);
    check("big_after_pop_level", 32'(level),        32'd7);
    drive(1'b1, 16'h8F, 1'b1);
    step();
    drive(1'b0, 16'h0, 1'b0);
    repeat (8) step();
    m_if.t_ready = 1'b0;
    check("big_drained", 32'(level), 32'd0);
`endif

    step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
